obi_arbiter_2to1: RTL and testbench
===================================

Name: obi_arbiter_2to1

Overview:
- Shares one OBI slave port between two OBI masters, for example the Wishbone-to-OBI bridge and a core data port.
- Arbitrates address phases with a locking round-robin policy.
- Records the winning master of every accepted request in an in-order ID FIFO.
- Routes each response phase (rvalid) back to the master that issued the request.
- Sits between the masters and the shared SRAM/peripheral OBI slave.

Parameters:
- MAX_OUTST, 4: maximum accepted-but-unresponded transactions. Legal values are 1..8, powers of two.
- AW, 32: address width.
- DW, 32: data width. Byte-enable width is DW/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- m_req_i  in  2  per-master request; bit n belongs to master n
- m_gnt_o  out  2  per-master grant
- m_addr_i  in  2*AW  master n address at [n*AW +: AW]
- m_we_i  in  2  write enable
- m_be_i  in  2*DW/8  byte enables
- m_wdata_i  in  2*DW  write data
- m_rvalid_o  out  2  per-master response valid
- m_rdata_o  out  DW  read data, broadcast to both masters
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_addr_o  out  AW  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  DW/8  slave byte enables
- s_wdata_o  out  DW  slave write data
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DW  slave read data
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - Round-robin pointer set to 0, so master 0 has priority.
  - Lock cleared; FIFO count and read/write pointers cleared; err_o=0.
  - While in reset: s_req_o=0, m_gnt_o=0, m_rvalid_o=0.
  - Reset mid-transaction drops all outstanding IDs. Later s_rvalid_i pulses are treated as spurious (see below).
- Selection (combinational), evaluated when not locked:
  - Exactly one m_req_i set: that master is selected.
  - Both set: the master indicated by the pointer is selected.
  - When locked, the selection is the registered lock_sel.
- Slave request:
  - s_req_o = m_req_i[sel] && !fifo_full.
  - s_addr_o, s_we_o, s_be_o and s_wdata_o mux from the selected master.
  - Rationale: no combinational path from s_rvalid_i to s_req_o; full FIFO blocks new requests even when a pop occurs in the same cycle.
- Lock: if s_req_o=1 and s_gnt_i=0, register lock_sel=sel and lock=1. This holds OBI address-phase stability. Lock clears on the cycle s_req_o && s_gnt_i.
- Grant: m_gnt_o[sel] = s_req_o && s_gnt_i, combinational, zero latency. The other grant bit is 0.
- Accept (s_req_o && s_gnt_i):
  - Push sel into the ID FIFO.
  - Pointer <= ~sel. This is round-robin after every accepted transfer, including an uncontested one.
- Response:
  - m_rvalid_o[fifo_head] = s_rvalid_i when FIFO is non-empty. The other bit is 0.
  - s_rvalid_i pops the FIFO.
  - m_rdata_o = s_rdata_i, unregistered.
  - Response latency through the block is 0 cycles.
- Simultaneous accept and response in one cycle: push and pop both occur and the count is unchanged. Legal only when the FIFO is not full (guaranteed by gating).
- Spurious response (s_rvalid_i=1 with FIFO empty): no m_rvalid_o is asserted and err_o is set. err_o stays 1 until reset.
- Wrap-around: FIFO pointers are log2(MAX_OUTST) bits wide and wrap naturally. Count is log2(MAX_OUTST)+1 bits wide.
- Deassertion of m_req_i while locked is an upstream protocol violation. In that case s_req_o drops, the lock clears on the next edge, and err_o is not set.

Decomposition:
- Package obi_pkg holds:
  - localparams for default widths;
  - a master-index typedef (1-bit);
  - the function clog2 if not already shared.
- Natural sub-module: obi_id_fifo, a parameterised synchronous FIFO (DEPTH, W) with push, pop, full, empty and head. It resets with rst_ni and supports simultaneous push and pop.
- Arbitration and lock logic stay in the top module.

Test Plan:
- Single master: m_req_i=01, s_gnt_i=1 every cycle, addr 0x100, read. Expect:
  - m_gnt_o=01 in the same cycle;
  - s_rvalid_i 2 cycles later with rdata 0xDEADBEEF gives m_rvalid_o=01 and m_rdata_o=0xDEADBEEF.
- Contention: m_req_i=11 held with s_gnt_i=1 for 4 cycles after reset. Expect grants 01,10,01,10 and s_addr_o alternating between the m0 and m1 addresses.
- Lock stability: m_req_i=01 with s_gnt_i=0 for 3 cycles, m1 raises req at cycle 1, then s_gnt_i=1. Expect:
  - s_addr_o holds the m0 address for all 4 cycles;
  - the grant goes to m0;
  - the next accepted transfer is m1.
- Full FIFO with MAX_OUTST=4: 4 accepted requests (m0,m1,m0,m1) with no rvalid. Expect:
  - s_req_o=0 on the 5th attempt;
  - 4 rvalid pulses route as 01,10,01,10;
  - s_req_o reasserts the cycle after the first pop.
- Simultaneous push and pop at count 2: accept and rvalid in the same cycle. Expect count stays 2 and the response goes to the oldest ID.
- Spurious rvalid with FIFO empty: expect m_rvalid_o=00 and err_o=1, held until rst_ni=0. Repeat with reset asserted while 3 transactions are outstanding: expect count 0 afterwards and err_o=1 on the next rvalid.

Source files
------------

// File: rtl/obi_pkg.sv
// obi_pkg: shared widths, master-index type and log2 helper for the OBI arbiter slice
package obi_pkg;

   localparam int OBI_AW = 32;
   localparam int OBI_DW = 32;

   typedef logic mid_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: in-order ID FIFO with simultaneous push/pop and natural pointer wrap
module obi_id_fifo
   import obi_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CW = clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr;
   logic [CW-1:0] count;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rptr];

   // storage is written on push only; contents need no reset since count gates reads
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= din;
   end

   // pointers and occupancy; push and pop in one cycle leave count unchanged
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= inc(wptr);
         if (pop) rptr <= inc(rptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// obi_arbiter_2to1: locking round-robin arbiter sharing one OBI slave between two masters
module obi_arbiter_2to1
   import obi_pkg::*;
#(
   parameter int MAX_OUTST = 4,
   parameter int AW        = OBI_AW,
   parameter int DW        = OBI_DW
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [1:0]        m_req_i,
   output logic [1:0]        m_gnt_o,
   input  logic [2*AW-1:0]   m_addr_i,
   input  logic [1:0]        m_we_i,
   input  logic [2*DW/8-1:0] m_be_i,
   input  logic [2*DW-1:0]   m_wdata_i,
   output logic [1:0]        m_rvalid_o,
   output logic [DW-1:0]     m_rdata_o,
   output logic              s_req_o,
   input  logic              s_gnt_i,
   output logic [AW-1:0]     s_addr_o,
   output logic              s_we_o,
   output logic [DW/8-1:0]   s_be_o,
   output logic [DW-1:0]     s_wdata_o,
   input  logic              s_rvalid_i,
   input  logic [DW-1:0]     s_rdata_i,
   output logic              err_o
);

   localparam int BW = DW / 8;

   mid_t sel;
   mid_t ptr;
   mid_t lock_sel;
   mid_t head;
   logic lock;
   logic full;
   logic empty;
   logic accept;
   logic pop;

   // a pending unaccepted request pins the selection; otherwise a lone requester wins, else the pointer
   assign sel = lock ? lock_sel : (m_req_i[0] ^ m_req_i[1]) ? m_req_i[1] : ptr;

   // a full ID FIFO blocks new requests, keeping s_rvalid_i off the s_req_o path
   assign s_req_o   = rst_ni && m_req_i[sel] && !full;
   assign accept    = s_req_o && s_gnt_i;
   assign m_gnt_o   = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign s_addr_o  = sel ? m_addr_i[2*AW-1:AW] : m_addr_i[AW-1:0];
   assign s_we_o    = sel ? m_we_i[1] : m_we_i[0];
   assign s_be_o    = sel ? m_be_i[2*BW-1:BW] : m_be_i[BW-1:0];
   assign s_wdata_o = sel ? m_wdata_i[2*DW-1:DW] : m_wdata_i[DW-1:0];

   // responses return in order to the master recorded at the FIFO head
   assign pop        = rst_ni && s_rvalid_i && !empty;
   assign m_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
   assign m_rdata_o  = s_rdata_i;

   // lock holds the address phase stable until granted; pointer flips after every accept
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr      <= 1'b0;
         lock     <= 1'b0;
         lock_sel <= 1'b0;
      end else begin
         lock <= s_req_o && !s_gnt_i;
         if (s_req_o && !s_gnt_i) lock_sel <= sel;
         if (accept) ptr <= ~sel;
      end
   end

   // a response with nothing outstanding is a protocol error, sticky until reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) err_o <= 1'b0;
      else if (s_rvalid_i && empty) err_o <= 1'b1;
   end

   obi_id_fifo #(
      .DEPTH(MAX_OUTST),
      .W    (1)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (accept),
      .pop   (pop),
      .din   (sel),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// tb_obi_arbiter_2to1: directed vector table plus randomized run against a queue-based reference model
module tb_obi_arbiter_2to1;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 4;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [1:0]      m_req_i;
   logic [1:0]      m_gnt_o;
   logic [2*AW-1:0] m_addr_i;
   logic [1:0]      m_we_i;
   logic [2*BW-1:0] m_be_i;
   logic [2*DW-1:0] m_wdata_i;
   logic [1:0]      m_rvalid_o;
   logic [DW-1:0]   m_rdata_o;
   logic            s_req_o;
   logic            s_gnt_i;
   logic [AW-1:0]   s_addr_o;
   logic            s_we_o;
   logic [BW-1:0]   s_be_o;
   logic [DW-1:0]   s_wdata_o;
   logic            s_rvalid_i;
   logic [DW-1:0]   s_rdata_i;
   logic            err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   obi_arbiter_2to1 #(.MAX_OUTST(MO), .AW(AW), .DW(DW)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
      .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
      .err_o(err_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit       rst;
      bit [1:0] req;
      bit       gnt;
      bit       rv;
      bit [1:0] egnt;
      bit [1:0] erv;
      bit       esreq;
      bit       em;
      bit       eerr;
   } vec_t;

   vec_t tbl[$];

   logic [AW-1:0] a_c [2];
   logic          we_c[2];
   logic [BW-1:0] be_c[2];
   logic [DW-1:0] wd_c[2];

   // reference model state
   int   prio;
   bit   lk;
   int   lsel;
   int   q[$];
   bit   merr;

   task automatic drive_masters();
      m_addr_i  = {a_c[1], a_c[0]};
      m_we_i    = {we_c[1], we_c[0]};
      m_be_i    = {be_c[1], be_c[0]};
      m_wdata_i = {wd_c[1], wd_c[0]};
   endtask

   task automatic chk_bus(input string tag, input int m);
      chk({tag, " s_addr"}, s_addr_o, a_c[m]);
      chk({tag, " s_we"}, s_we_o, we_c[m]);
      chk({tag, " s_be"}, s_be_o, be_c[m]);
      chk({tag, " s_wdata"}, s_wdata_o, wd_c[m]);
   endtask

   initial begin
      a_c[0] = 32'h100; we_c[0] = 1'b0; be_c[0] = 4'hF; wd_c[0] = 32'h1111_1111;
      a_c[1] = 32'h200; we_c[1] = 1'b1; be_c[1] = 4'h3; wd_c[1] = 32'h2222_2222;
      drive_masters();
      rst_ni = 1'b0; m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
      s_rdata_i = 32'hDEAD_BEEF;
      //                 rst  req   gnt  rv   egnt  erv   sreq m    err
      tbl.push_back(vec_t'{1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // reset state
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0}); // single master
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0}); // response
      tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // reset
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0}); // contention
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0}); // fifo full
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // 5th blocked
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0}); // pop, still blocked
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0}); // reasserts
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0}); // lock m0
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0}); // m1 next
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0}); // push+pop at 2
      tbl.push_back(vec_t'{1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // count was 2
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // spurious
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1});
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1}); // err sticky
      tbl.push_back(vec_t'{1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1}); // 3 outstanding
      tbl.push_back(vec_t'{1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1}); // reset
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // ids dropped
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1});
      tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1});
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0}); // lock m1
      tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}); // req dropped
      tbl.push_back(vec_t'{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0}); // lock gone

      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         rst_ni = tbl[i].rst; m_req_i = tbl[i].req; s_gnt_i = tbl[i].gnt; s_rvalid_i = tbl[i].rv;
         #1;
         chk({tag, " m_gnt"}, m_gnt_o, tbl[i].egnt);
         chk({tag, " m_rvalid"}, m_rvalid_o, tbl[i].erv);
         chk({tag, " s_req"}, s_req_o, tbl[i].esreq);
         chk({tag, " err"}, err_o, tbl[i].eerr);
         if (tbl[i].esreq) chk_bus(tag, int'(tbl[i].em));
         if (tbl[i].rv) chk({tag, " m_rdata"}, m_rdata_o, 32'hDEAD_BEEF);
         @(negedge clk);
      end

      // randomized run against the reference model
      prio = 0; lk = 1'b0; lsel = 0; merr = 1'b0; q.delete();
      for (int c = 0; c < 3000; c++) begin
         int       sel;
         bit       esreq;
         bit [1:0] egnt;
         bit [1:0] erv;
         string    tag;
         tag = $sformatf("rnd%0d", c);
         rst_ni     = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         m_req_i    = 2'($urandom);
         s_gnt_i    = ($urandom_range(0, 2) != 0);
         s_rvalid_i = ($urandom_range(0, 2) == 0);
         s_rdata_i  = $urandom;
         for (int m = 0; m < 2; m++) begin
            a_c[m] = $urandom; we_c[m] = 1'($urandom); be_c[m] = 4'($urandom); wd_c[m] = $urandom;
         end
         drive_masters();
         #1;
         if (lk) sel = lsel;
         else if (m_req_i == 2'b01) sel = 0;
         else if (m_req_i == 2'b10) sel = 1;
         else sel = prio;
         esreq = rst_ni && m_req_i[sel] && (q.size() < MO);
         egnt  = (esreq && s_gnt_i) ? 2'(1 << sel) : 2'b00;
         erv   = (rst_ni && s_rvalid_i && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
         chk({tag, " m_gnt"}, m_gnt_o, egnt);
         chk({tag, " m_rvalid"}, m_rvalid_o, erv);
         chk({tag, " s_req"}, s_req_o, esreq);
         chk({tag, " err"}, err_o, merr);
         chk({tag, " m_rdata"}, m_rdata_o, s_rdata_i);
         if (esreq) chk_bus(tag, sel);
         if (!rst_ni) begin
            prio = 0; lk = 1'b0; merr = 1'b0; q.delete();
         end else begin
            if (s_rvalid_i) begin
               if (q.size() > 0) void'(q.pop_front());
               else merr = 1'b1;
            end
            if (egnt != 2'b00) begin
               q.push_back(sel);
               prio = 1 - sel;
            end
            lk   = esreq && !s_gnt_i;
            lsel = sel;
         end
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
